// File: rtl/arbitro_qos_if.sv
// Bus between the QoS arbiter and the four class FIFOs / intermediate-data mux.
// master is the arbiter side; slave is the FIFO/mux side.
interface arbitro_qos_if;
    logic       EMPTYff0;
    logic       EMPTYff1;
    logic       EMPTYff2;
    logic       EMPTYff3;
    logic       PAUSE;
    logic       POPff0;
    logic       POPff1;
    logic       POPff2;
    logic       POPff3;
    logic       VALID_OUT;
    logic [1:0] GRANT_ID;
    logic       IDLE;

    modport master (
        input  EMPTYff0, EMPTYff1, EMPTYff2, EMPTYff3, PAUSE,
        output POPff0, POPff1, POPff2, POPff3, VALID_OUT, GRANT_ID, IDLE
    );

    modport slave (
        output EMPTYff0, EMPTYff1, EMPTYff2, EMPTYff3, PAUSE,
        input  POPff0, POPff1, POPff2, POPff3, VALID_OUT, GRANT_ID, IDLE
    );
endinterface

// File: rtl/arbitro_qos.sv
// Weighted round-robin arbiter over four class FIFOs; at most one pop per cycle,
// bandwidth shared in proportion to the per-class quanta.
module arbitro_qos #(
    parameter int unsigned WEIGHT0 = 4,
    parameter int unsigned WEIGHT1 = 3,
    parameter int unsigned WEIGHT2 = 2,
    parameter int unsigned WEIGHT3 = 1,
    parameter int unsigned CNT_W   = 3
) (
    input logic           CLOCK,
    input logic           RESET,
    arbitro_qos_if.master bus
);

    typedef enum logic [1:0] {StIdle, StServe, StPaused} state_e;

    // A zero (or truncated-to-zero) weight would stall a class forever, so load 1.
    function automatic logic [CNT_W-1:0] fix_weight(input int unsigned w);
        logic [CNT_W-1:0] t;
        t = CNT_W'(w);
        return (t == '0) ? CNT_W'(1) : t;
    endfunction

    localparam logic [CNT_W-1:0] Q0 = fix_weight(WEIGHT0);
    localparam logic [CNT_W-1:0] Q1 = fix_weight(WEIGHT1);
    localparam logic [CNT_W-1:0] Q2 = fix_weight(WEIGHT2);
    localparam logic [CNT_W-1:0] Q3 = fix_weight(WEIGHT3);

    function automatic logic [CNT_W-1:0] quantum(input logic [1:0] idx);
        logic [CNT_W-1:0] q;
        case (idx)
            2'd0:    q = Q0;
            2'd1:    q = Q1;
            2'd2:    q = Q2;
            default: q = Q3;
        endcase
        return q;
    endfunction

    state_e           state_q, state_d;
    logic [1:0]       ptr_q, ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             valid_q;
    logic [1:0]       grant_q;

    logic [3:0] empty;
    logic [3:0] pop;
    logic [1:0] nxt;
    logic [1:0] cand;
    logic       found;
    logic       serve_ok;

    assign empty = {bus.EMPTYff3, bus.EMPTYff2, bus.EMPTYff1, bus.EMPTYff0};

    // Search ptr+1, ptr+2, ptr+3 and finally ptr itself for a non-empty class.
    always_comb begin
        nxt   = ptr_q;
        cand  = ptr_q;
        found = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            cand = ptr_q + 2'(k);
            if (!found && !empty[cand]) begin
                nxt   = cand;
                found = 1'b1;
            end
        end
    end

    always_comb begin
        serve_ok = (state_q == StServe) && !empty[ptr_q] && !bus.PAUSE && (cnt_q != '0);
        pop      = serve_ok ? (4'b0001 << ptr_q) : 4'b0000;
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        case (state_q)
            StIdle: begin
                if (!(&empty)) begin
                    ptr_d   = nxt;
                    cnt_d   = quantum(nxt);
                    state_d = StServe;
                end
            end
            StServe: begin
                if (bus.PAUSE) begin
                    state_d = StPaused;
                end else if (&empty) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else if (empty[ptr_q] || (cnt_q <= CNT_W'(1))) begin
                    // Bubble on a drained class, or last pop of the quantum.
                    ptr_d = nxt;
                    cnt_d = quantum(nxt);
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            StPaused: begin
                if (!bus.PAUSE) begin
                    state_d = StServe;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            state_q <= StIdle;
            ptr_q   <= 2'd3;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            grant_q <= 2'd0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            valid_q <= |pop;
            if (|pop) begin
                grant_q <= ptr_q;
            end
        end
    end

    assign bus.POPff0    = pop[0];
    assign bus.POPff1    = pop[1];
    assign bus.POPff2    = pop[2];
    assign bus.POPff3    = pop[3];
    assign bus.VALID_OUT = valid_q;
    assign bus.GRANT_ID  = grant_q;
    assign bus.IDLE      = (state_q == StIdle);

endmodule

// File: tb/tb_arbitro_qos.sv
// Scoreboard bench for arbitro_qos: directed phases push hand-written per-cycle
// expectations; a negedge monitor pops and compares them against the DUT.
module tb_arbitro_qos;

    typedef struct {
        logic [3:0] pop;
        logic       idle;
    } exp_t;

    logic CLOCK;
    logic RESET;

    arbitro_qos_if bus ();

    arbitro_qos #(
        .WEIGHT0(4),
        .WEIGHT1(3),
        .WEIGHT2(2),
        .WEIGHT3(1),
        .CNT_W  (3)
    ) dut (
        .CLOCK(CLOCK),
        .RESET(RESET),
        .bus  (bus.master)
    );

    exp_t       exp_q[$];
    int         n_total = 0;
    int         n_bad   = 0;
    int         fcnt[4];
    logic [3:0] pop_s;
    logic [3:0] pop_now;
    logic [3:0] prev_pop;
    logic [1:0] exp_grant;

    assign pop_now = {bus.POPff3, bus.POPff2, bus.POPff1, bus.POPff0};

    initial begin
        CLOCK = 1'b0;
        forever #5 CLOCK = ~CLOCK;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h want %0h", name, $time, act, exp);
        end
    endtask

    // Monitor: POP and IDLE must match this cycle's entry; VALID_OUT and GRANT_ID
    // must reflect the previous cycles' expected pops.
    initial begin
        exp_t e;
        prev_pop  = 4'b0;
        exp_grant = 2'd0;
        pop_s     = 4'b0;
        forever begin
            @(negedge CLOCK);
            pop_s = pop_now;
            if (!RESET) begin
                prev_pop  = 4'b0;
                exp_grant = 2'd0;
            end
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("pop", pop_now, e.pop);
                check("idle", {3'b0, bus.IDLE}, {3'b0, e.idle});
                check("valid", {3'b0, bus.VALID_OUT}, {3'b0, |prev_pop});
                check("grant", {2'b0, bus.GRANT_ID}, {2'b0, exp_grant});
                for (int i = 0; i < 4; i++) begin
                    if (e.pop[i]) exp_grant = 2'(i);
                end
                prev_pop = e.pop;
            end
        end
    end

    task automatic drive_empty();
        bus.EMPTYff0 = (fcnt[0] == 0);
        bus.EMPTYff1 = (fcnt[1] == 0);
        bus.EMPTYff2 = (fcnt[2] == 0);
        bus.EMPTYff3 = (fcnt[3] == 0);
    endtask

    task automatic set_counts(input int c0, input int c1, input int c2, input int c3);
        fcnt[0] = c0;
        fcnt[1] = c1;
        fcnt[2] = c2;
        fcnt[3] = c3;
        drive_empty();
    endtask

    // FIFO model: a pop seen in the last cycle removes one word before EMPTY is redriven.
    task automatic cycle();
        @(posedge CLOCK);
        #1;
        for (int i = 0; i < 4; i++) begin
            if (pop_s[i] && fcnt[i] != 0) fcnt[i]--;
        end
        drive_empty();
    endtask

    // 'i' = idle, '-' = serving/paused with no pop, '0'..'3' = pop of that class.
    task automatic phase(input string s);
        exp_t e;
        byte  c;
        for (int i = 0; i < s.len(); i++) begin
            c = s[i];
            e.idle = (c == "i");
            e.pop  = 4'b0;
            if (c >= "0" && c <= "3") e.pop = 4'b0001 << (c - "0");
            exp_q.push_back(e);
        end
        repeat (s.len()) cycle();
    endtask

    task automatic reset_pulse();
        RESET = 1'b0;
        phase("ii");
        RESET = 1'b1;
    endtask

    initial begin
        RESET     = 1'b0;
        bus.PAUSE = 1'b0;
        set_counts(0, 0, 0, 0);
        cycle();

        // Reset and idle.
        phase("iii");
        RESET = 1'b1;
        phase("ii");

        // All classes backlogged.
        set_counts(1000, 1000, 1000, 1000);
        phase("i00001112230000111223");
        set_counts(0, 0, 0, 0);
        phase("-i");

        // Single class active: quantum reload without bubble.
        set_counts(0, 0, 1000, 0);
        phase("i222222222");
        set_counts(0, 0, 0, 0);
        phase("-i");

        // Back-pressure mid-quantum.
        set_counts(1000, 1000, 0, 0);
        phase("i00");
        bus.PAUSE = 1'b1;
        phase("----");
        bus.PAUSE = 1'b0;
        phase("-00111");
        set_counts(0, 0, 0, 0);
        phase("-i");

        // Class drains mid-quantum.
        reset_pulse();
        set_counts(2, 1000, 0, 0);
        phase("i00-111111");
        set_counts(0, 0, 0, 0);
        phase("-i");

        // Reset mid-burst during class 1 service.
        reset_pulse();
        set_counts(1000, 1000, 1000, 1000);
        phase("i00001");
        #1;
        check("midburst_pop1", {3'b0, bus.POPff1}, 4'b0001);
        #1;
        RESET = 1'b0;
        #1;
        check("async_pop", pop_now, 4'b0000);
        check("async_valid", {3'b0, bus.VALID_OUT}, 4'b0000);
        check("async_grant", {2'b0, bus.GRANT_ID}, 4'b0000);
        check("async_idle", {3'b0, bus.IDLE}, 4'b0001);
        cycle();
        cycle();
        RESET = 1'b1;
        phase("i0000111223");
        set_counts(0, 0, 0, 0);
        phase("-i");

        check("queue_drained", 4'(exp_q.size()), 4'b0000);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/arbitro_qos.md
# arbitro_qos

Weighted round-robin QoS arbiter that sits directly upstream of the intermediate-data mux. It watches the empty flags of the four class FIFOs (ff0..ff3) and the downstream back-pressure flag, and each cycle drives at most one of POPff0..POPff3. The mux uses that pop to capture the granted FIFO's data. Bandwidth is shared in proportion to per-class weights (quanta), and a companion VALID_OUT marks the cycle in which DATOCF_OUT holds fresh data.

## Interface
- WEIGHT0, default 4: pops per turn for class 0. Legal range 1..2^CNT_W-1; 0 is treated as 1.
- WEIGHT1, default 3: quantum for class 1.
- WEIGHT2, default 2: quantum for class 2.
- WEIGHT3, default 1: quantum for class 3.
- CNT_W, default 3: width of the quantum counter.
- CLOCK  in  1  sole clock, rising edge.
- RESET  in  1  asynchronous, active-low. 0 means in reset; operation requires 1.
- EMPTYff0..EMPTYff3  in  1 each  empty flag of the class FIFO, 1 = empty.
- PAUSE  in  1  downstream almost-full, 1 = stop popping.
- POPff0..POPff3  out  1 each  pop strobe to FIFO i and the mux. Combinational from state and current inputs; at most one is high.
- VALID_OUT  out  1  registered; 1 in the cycle after any POP, aligned with the new DATOCF_OUT.
- GRANT_ID  out  2  registered index of the last popped class.
- IDLE  out  1  registered; 1 while the FSM is in IDLE.

## Operation
- State registers:
  - 2-bit FSM state: IDLE, SERVE, PAUSED.
  - 2-bit ptr, the class currently being served.
  - CNT_W-bit cnt, the pops remaining in the current quantum.
- Pop rule: POPffi = (state==SERVE) & (ptr==i) & !EMPTYffi & !PAUSE & (cnt!=0). All POPs are 0 in IDLE and PAUSED.
- next(ptr) = first non-empty class in the order ptr+1, ptr+2, ptr+3, then ptr itself, evaluated on the current EMPTY flags. The 2-bit index wraps from 3 to 0.
- IDLE:
  - If any EMPTYff is 0: ptr<=next(ptr), cnt<=WEIGHT[next], go to SERVE.
  - Otherwise stay in IDLE.
- SERVE, evaluated in priority order:
  - PAUSE=1: go to PAUSED; ptr and cnt held.
  - All FIFOs empty: go to IDLE; cnt<=0.
  - EMPTYff[ptr]=1: bubble cycle with no pop; ptr<=next(ptr), cnt<=WEIGHT[next].
  - Pop with cnt==1: ptr<=next(ptr), cnt<=WEIGHT[next]. If the other classes are empty, next is ptr itself and its quantum is reloaded.
  - Pop with cnt>1: cnt<=cnt-1.
- PAUSED:
  - No pops; ptr and cnt held.
  - When PAUSE=0: go to SERVE, resuming the remaining quantum.
- VALID_OUT <= |POP. GRANT_ID <= index of the asserted POP; it holds when there is no pop.
- The weights are static parameters. cnt never underflows, and a weight of 0 is loaded as 1.

## Timing
- Reset (asynchronous, RESET low) gives: state=IDLE, ptr=3 (so the first search starts at class 0), cnt=0, VALID_OUT=0, GRANT_ID=0, IDLE=1. All POPs drop to 0 immediately.
- Reset released mid-burst: the arbiter restarts from class 0 with a full quantum.
- Start-up latency: a FIFO that goes non-empty while the FSM is in IDLE gets its first POP 1 cycle later (IDLE→SERVE transition cycle).
- Back-to-back pops are allowed; the steady-state rate is 1 pop per cycle.
- Switching classes costs no cycle when the quantum expires. It costs one bubble cycle when the served class empties mid-quantum.
- PAUSE gates POP in the same cycle it rises. Popping resumes in the cycle after PAUSE falls (PAUSED→SERVE).
- VALID_OUT and DATOCF_OUT update on the same edge: one cycle after POP.
- Data dependency: the upstream FIFO's EMPTY must reflect a pop by the next cycle. The arbiter re-evaluates EMPTY every cycle, so the last word of a FIFO is never popped twice.

## Test plan
- Reset and idle:
  - Stimulus: hold RESET=0 for 3 cycles with all EMPTY=1, then release.
  - Required: POPs=0, VALID_OUT=0, GRANT_ID=0, IDLE=1 throughout.
- All classes backlogged (default weights):
  - Stimulus: all EMPTY=0.
  - Required: POP sequence 0,0,0,0,1,1,1,2,2,3 repeating with no gaps. VALID_OUT follows one cycle later and GRANT_ID matches.
- Single class active:
  - Stimulus: only EMPTYff2=0 for 10 cycles.
  - Required: POPff2 high every cycle from the second cycle onward, with the quantum reloaded every 2 pops and no bubble.
- Back-pressure mid-quantum:
  - Stimulus: class 0 backlogged; PAUSE rises after 2 pops and is held 4 cycles.
  - Required: no POP while PAUSE=1. Then exactly 2 more pops of class 0 before class 1 is served.
- Class drains mid-quantum:
  - Stimulus: ff0 holds 2 words; ff1 is backlogged.
  - Required: pops 0,0, then one bubble cycle with no POP, then 3 pops of class 1.
- Reset mid-burst:
  - Stimulus: assert RESET=0 asynchronously between clock edges during class 1 service.
  - Required: POPff1 falls immediately and outputs go to their reset values. After release, service restarts at class 0 with cnt=4.
